// File: rtl/apb_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regbank
// Description : APB slave with a bank of DEPTH registers, each DATA_W bits
//               wide. WAIT_CYC wait states are inserted in every access.
//               Out-of-range or misaligned addresses return an error and are
//               never written.
//               Optional feature macro: APB_REGBANK_PSTRB_EN adds the pstrb
//               byte-strobe input port.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regbank #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
`ifdef APB_REGBANK_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int c_NBYTES = DATA_W / 8;
    localparam int c_BYTE_W = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 0;
    localparam int c_IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_SIZE = ADDR_W'(DEPTH * c_NBYTES);
    localparam logic [3:0] c_WAIT = 4'(WAIT_CYC);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_err;
    logic                 r_write;
    logic [c_NBYTES-1:0]  r_strb;
    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic [DATA_W-1:0]    r_prdata;
    logic                 r_pready;
    logic                 r_pslverr;

    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_misalign;
    logic                 w_err;
    logic                 w_setup;
    logic                 w_commit;
    logic [c_NBYTES-1:0]  w_strb_in;
    logic [DATA_W-1:0]    w_wmask;
    logic [3:0]           w_cnt_inc;

    // Word index selects whole registers; low byte-offset bits are dropped.
    assign w_idx   = paddr[c_IDX_W+c_BYTE_W-1 : c_BYTE_W];
    assign w_setup = psel & ~penable;

    generate
        if (c_BYTE_W > 0) begin : g_align
            assign w_misalign = |paddr[c_BYTE_W-1:0];
        end else begin : g_no_align
            assign w_misalign = 1'b0;
        end
    endgenerate

    assign w_err = (paddr >= c_SIZE) | w_misalign;

`ifdef APB_REGBANK_PSTRB_EN
    assign w_strb_in = pstrb;
`else
    assign w_strb_in = '1;
`endif

    // Expand the latched byte strobes into a bit-level write mask.
    generate
        for (genvar b = 0; b < c_NBYTES; b++) begin : g_mask
            assign w_wmask[8*b +: 8] = {8{r_strb[b]}};
        end
    endgenerate

    // A write lands only on the edge closing a completed, error-free access;
    // a fresh setup phase or reset on that edge takes precedence.
    assign w_commit = (r_state == S_ACCESS) & psel & penable & r_pready
                    & r_write & ~r_err & ~preset;

    assign w_cnt_inc = r_cnt + 4'd1;

    // Transfer FSM: latches the request on setup, counts wait states and
    // produces registered pready/pslverr/prdata.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_write   <= 1'b0;
            r_strb    <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else if (w_setup) begin
            // Setup is honoured in any state and abandons a pending access.
            r_state   <= S_ACCESS;
            r_cnt     <= 4'd0;
            r_idx     <= w_idx;
            r_err     <= w_err;
            r_write   <= pwrite;
            r_strb    <= w_strb_in;
            r_pready  <= (c_WAIT == 4'd0);
            r_pslverr <= (c_WAIT == 4'd0) & w_err;
            if (!pwrite) begin
                r_prdata <= w_err ? '0 : r_mem[w_idx];
            end
        end else begin
            case (r_state)
                S_ACCESS: begin
                    if (!psel || r_pready) begin
                        // Aborted by deselect, or the access just completed.
                        r_state   <= S_IDLE;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                    end else begin
                        r_cnt     <= w_cnt_inc;
                        r_pready  <= (w_cnt_inc == c_WAIT);
                        r_pslverr <= (w_cnt_inc == c_WAIT) & r_err;
                    end
                end
                default: begin
                    // Stray penable without a setup phase is ignored.
                    r_state   <= S_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
            endcase
        end
    end

    // Register file: cleared by reset, byte-masked update on commit.
    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_idx] <= (r_mem[r_idx] & ~w_wmask) | (pwdata & w_wmask);
        end
    end

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_regbank
// Description : Directed bench for apb_slave_regbank. Two instances (0 and 3
//               wait states) share one APB bus; a protocol-level model of each
//               predicts pready/pslverr/prdata every cycle, and hand-computed
//               literals pin the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regbank;

    logic        clk = 1'b0;
    logic        preset, psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    logic        rdy_o [2];
    logic        err_o [2];
    logic [31:0] rd_o  [2];

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    apb_slave_regbank #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_CYC(0)) u_dut0 (
        .pclk(clk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_REGBANK_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave_regbank #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_CYC(3)) u_dut3 (
        .pclk(clk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_REGBANK_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    assign rdy_o[0] = pready0;  assign rdy_o[1] = pready3;
    assign err_o[0] = pslverr0; assign err_o[1] = pslverr3;
    assign rd_o[0]  = prdata0;  assign rd_o[1]  = prdata3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit bad(input logic [31:0] a);
        return (a >= 32'd64) || ((a % 4) != 0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    logic        m_active [2];
    int          m_el     [2];
    logic [31:0] m_addr   [2];
    logic        m_wr     [2];
    logic [3:0]  m_strb   [2];
    logic [31:0] m_prd    [2];
    logic [31:0] m_mem    [2][16];
    logic [3:0]  strb_eff;

`ifdef APB_REGBANK_PSTRB_EN
    assign strb_eff = pstrb;
`else
    assign strb_eff = 4'hF;
`endif

    // Model: a transfer starts on a setup phase, completes wait_of(k) cycles
    // into ACCESS, and writes memory only if still selected and error-free.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (preset) begin
                m_active[k] <= 1'b0;
                m_el[k]     <= 0;
                m_prd[k]    <= '0;
                m_addr[k]   <= '0;
                m_wr[k]     <= 1'b0;
                for (int i = 0; i < 16; i++) m_mem[k][i] <= '0;
            end else if (psel && !penable) begin
                m_active[k] <= 1'b1;
                m_el[k]     <= 0;
                m_addr[k]   <= paddr;
                m_wr[k]     <= pwrite;
                m_strb[k]   <= strb_eff;
                if (!pwrite) m_prd[k] <= bad(paddr) ? 32'd0 : m_mem[k][paddr / 4];
            end else if (m_active[k]) begin
                if (!psel) begin
                    m_active[k] <= 1'b0;
                end else if (m_el[k] == wait_of(k)) begin
                    m_active[k] <= 1'b0;
                    if (m_wr[k] && !bad(m_addr[k]))
                        m_mem[k][m_addr[k] / 4] <= merge(m_mem[k][m_addr[k] / 4], pwdata, m_strb[k]);
                end else begin
                    m_el[k] <= m_el[k] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                logic exp_rdy;
                exp_rdy = m_active[k] && (m_el[k] == wait_of(k));
                chk($sformatf("pready[%0d]", k), {31'd0, rdy_o[k]}, {31'd0, exp_rdy});
                chk($sformatf("pslverr[%0d]", k), {31'd0, err_o[k]},
                    {31'd0, exp_rdy && bad(m_addr[k])});
                if (exp_rdy && !m_wr[k])
                    chk($sformatf("prdata[%0d]", k), rd_o[k], m_prd[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    int          rdy_at [2];
    logic        err_at [2];
    logic [31:0] rd_at  [2];

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0; preset = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One transfer: setup cycle, then nacc ACCESS cycles; preset is raised
    // during ACCESS cycle rst_at (0 = never). Records, per instance, the
    // ACCESS cycle of the first pready and the pslverr/prdata seen there.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int nacc, input int rst_at);
        for (int k = 0; k < 2; k++) begin
            rdy_at[k] = 0; err_at[k] = 1'b0; rd_at[k] = 32'hxxxx_xxxx;
        end
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        preset = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= nacc; i++) begin
            penable = 1'b1;
            preset  = (i == rst_at);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rdy_at[k] == 0 && rdy_o[k]) begin
                    rdy_at[k] = i; err_at[k] = err_o[k]; rd_at[k] = rd_o[k];
                end
            end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0; preset = 1'b0;
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        preset = 1'b0;
        @(negedge clk);
        chk("reset_pready0", {31'd0, pready0}, 32'd0);
        chk("reset_pready3", {31'd0, pready3}, 32'd0);
        chk("reset_pslverr0", {31'd0, pslverr0}, 32'd0);
        chk("reset_prdata0", prdata0, 32'd0);
        chk("reset_prdata3", prdata3, 32'd0);
        @(posedge clk); #1;

        // Basic write/read at 0x08; ready latency of each instance.
        xfer(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 4, 0);
        chk("wr08_rdy_at0", rdy_at[0], 32'd1);
        chk("wr08_rdy_at3", rdy_at[1], 32'd4);
        chk("wr08_err0", {31'd0, err_at[0]}, 32'd0);
        xfer(1'b0, 32'h08, 32'h0, 4'hF, 4, 0);
        chk("rd08_data0", rd_at[0], 32'hDEADBEEF);
        chk("rd08_data3", rd_at[1], 32'hDEADBEEF);
        chk("rd08_err3", {31'd0, err_at[1]}, 32'd0);

        // Read of 0x04 on the 3-wait instance.
        xfer(1'b0, 32'h04, 32'h0, 4'hF, 4, 0);
        chk("rd04_rdy_at3", rdy_at[1], 32'd4);
        chk("rd04_data3", rd_at[1], 32'd0);

        // Out-of-range and misaligned writes report errors and change nothing.
        xfer(1'b1, 32'h40, 32'h55AA55AA, 4'hF, 4, 0);
        chk("wr40_err0", {31'd0, err_at[0]}, 32'd1);
        chk("wr40_err3", {31'd0, err_at[1]}, 32'd1);
        xfer(1'b1, 32'h06, 32'hCAFEF00D, 4'hF, 4, 0);
        chk("wr06_err0", {31'd0, err_at[0]}, 32'd1);
        chk("wr06_err3", {31'd0, err_at[1]}, 32'd1);
        xfer(1'b0, 32'h00, 32'h0, 4'hF, 4, 0);
        chk("rd00_data0", rd_at[0], 32'd0);
        xfer(1'b0, 32'h04, 32'h0, 4'hF, 4, 0);
        chk("rd04b_data0", rd_at[0], 32'd0);
        chk("rd04b_data3", rd_at[1], 32'd0);
        xfer(1'b0, 32'h40, 32'h0, 4'hF, 4, 0);
        chk("rd40_err3", {31'd0, err_at[1]}, 32'd1);
        chk("rd40_data3", rd_at[1], 32'd0);

        // penable without a setup phase is ignored.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        idle(1);
        xfer(1'b0, 32'h00, 32'h0, 4'hF, 4, 0);
        chk("stray_data0", rd_at[0], 32'd0);
        chk("stray_data3", rd_at[1], 32'd0);

        // Reset in the ready cycle of a write: nothing commits.
        xfer(1'b1, 32'h0C, 32'h12345678, 4'hF, 1, 1);
        @(negedge clk);
        chk("post_rst_pready0", {31'd0, pready0}, 32'd0);
        chk("post_rst_prdata0", prdata0, 32'd0);
        chk("post_rst_prdata3", prdata3, 32'd0);
        chk("post_rst_pslverr3", {31'd0, pslverr3}, 32'd0);
        @(posedge clk); #1;
        xfer(1'b0, 32'h0C, 32'h0, 4'hF, 4, 0);
        chk("rd0C_data0", rd_at[0], 32'd0);
        xfer(1'b1, 32'h0C, 32'h12345678, 4'hF, 4, 4);
        idle(1);
        xfer(1'b0, 32'h0C, 32'h0, 4'hF, 4, 0);
        chk("rd0Cb_data3", rd_at[1], 32'd0);

        // Setup during ACCESS abandons the slower instance's write.
        xfer(1'b1, 32'h14, 32'h11111111, 4'hF, 1, 0);
        xfer(1'b0, 32'h14, 32'h0, 4'hF, 4, 0);
        chk("rd14_data0", rd_at[0], 32'h11111111);
        chk("rd14_data3", rd_at[1], 32'd0);

        // Deselect mid-ACCESS, then back-to-back write/read to 0x10.
        xfer(1'b1, 32'h10, 32'hAAAA5555, 4'hF, 1, 0);
        idle(1);
        xfer(1'b0, 32'h10, 32'h0, 4'hF, 4, 0);
        chk("rd10_data0", rd_at[0], 32'hAAAA5555);
        chk("rd10_data3", rd_at[1], 32'd0);
        xfer(1'b1, 32'h10, 32'h0BADF00D, 4'hF, 4, 0);
        xfer(1'b0, 32'h10, 32'h0, 4'hF, 4, 0);
        chk("b2b_rdy_at3", rdy_at[1], 32'd4);
        chk("b2b_data0", rd_at[0], 32'h0BADF00D);
        chk("b2b_data3", rd_at[1], 32'h0BADF00D);

`ifdef APB_REGBANK_PSTRB_EN
        // Byte strobes: only bytes 0 and 2 are cleared.
        xfer(1'b1, 32'h18, 32'hFFFFFFFF, 4'hF, 4, 0);
        xfer(1'b1, 32'h18, 32'h00000000, 4'b0101, 4, 0);
        xfer(1'b0, 32'h18, 32'h0, 4'hF, 4, 0);
        chk("strb_data0", rd_at[0], 32'hFF00FF00);
        chk("strb_data3", rd_at[1], 32'hFF00FF00);
`endif

        idle(2);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_slave_regbank.md
APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

Interface
REQ-001 Parameter DATA_W, 32, data bus width in bits (multiple of 8).
REQ-002 Parameter ADDR_W, 32, address bus width in bits.
REQ-003 Parameter DEPTH, 16, number of DATA_W-bit registers (power of two, >= 2).
REQ-004 Parameter WAIT_CYC, 0, wait states inserted in every ACCESS phase (0..15).
REQ-005 pclk  input  1  clock; all logic is on the rising edge.
REQ-006 preset  input  1  reset; synchronous, active-high.
REQ-007 psel  input  1  slave select.
REQ-008 penable  input  1  access-phase indicator.
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 paddr  input  ADDR_W  byte address.
REQ-011 pwdata  input  DATA_W  write data.
REQ-012 prdata  output  DATA_W  read data; valid only while pready=1.
REQ-013 pready  output  1  transfer-complete strobe.
REQ-014 pslverr  output  1  error response; valid only while pready=1.

Function
REQ-015 The FSM SHALL have two states: IDLE and ACCESS. The state, wait counter, latched index, latched error flag and prdata SHALL all be registered.
REQ-016 Setup phase: psel=1, penable=0, any state. On that edge the block SHALL latch pwrite, word index = paddr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)] and the error flag, clear the counter, and enter ACCESS.
REQ-017 Error flag: paddr >= DEPTH*DATA_W/8, or paddr is not aligned to DATA_W/8 bytes.
REQ-018 In ACCESS, pready SHALL equal (counter == WAIT_CYC). The counter SHALL increment each cycle while pready=0. The first pready therefore falls WAIT_CYC cycles after the first ACCESS cycle.
REQ-019 In ACCESS with pready=1, pslverr SHALL equal the latched error flag. In every other cycle pslverr SHALL be 0.
REQ-020 Write, no error: the register SHALL be updated on the edge that ends the pready=1 cycle. An errored write SHALL change no register.
REQ-021 Read: on the setup edge prdata SHALL capture the addressed register, or 0 if in error. prdata SHALL hold until the next setup edge.
REQ-022 The edge that ends the pready=1 cycle SHALL return the FSM to IDLE. A setup phase in the following cycle SHALL be accepted, giving back-to-back transfers with no idle cycle.
REQ-023 psel=0 in ACCESS before pready=1: the FSM SHALL abort to IDLE, perform no write and leave prdata unchanged.
REQ-024 penable=1 in IDLE (no preceding setup) SHALL be ignored: pready stays 0 and no write occurs.
REQ-025 A setup phase seen in ACCESS (psel=1, penable=0) SHALL abandon the current transfer without a write and start the new one per REQ-016.

Reset
REQ-026 While preset=1 at a rising edge, the block SHALL force state=IDLE, counter=0, prdata=0, pready=0, pslverr=0 and all registers to 0.
REQ-027 Reset SHALL take priority over every transfer in progress. A write whose pready=1 cycle coincides with preset=1 SHALL NOT commit.

Configuration
REQ-028 Macro APB_REGBANK_PSTRB_EN defined: add port pstrb, input, width DATA_W/8, byte write strobes. A write SHALL update only the bytes whose strobe bit is 1. pstrb SHALL be latched on the setup edge.
REQ-029 Macro undefined: no pstrb port exists and every non-error write SHALL update the full word.

Verification
REQ-030 WAIT_CYC=0: write 0xDEADBEEF to 0x08, then read 0x08. Expect pready on the second cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
REQ-031 WAIT_CYC=3: read 0x04. Expect pready=0 for 3 ACCESS cycles, then 1 on the 4th.
REQ-032 DEPTH=16: write to 0x40, and write to misaligned 0x06. Expect pslverr=1 with pready=1 for both, and a readback of 0x00/0x04 unchanged.
REQ-033 Assert preset in the pready cycle of a write of 0x12345678 to 0x0C. Expect a read of 0x0C to return 0 and all outputs to be 0 after reset.
REQ-034 Drop psel mid-ACCESS during a write, then run back-to-back write/read to 0x10. Expect no write from the aborted transfer and no idle cycle between the back-to-back transfers.
REQ-035 With APB_REGBANK_PSTRB_EN: preload 0xFFFFFFFF, then write 0x00000000 with pstrb=4'b0101. Expect a read of 0xFF00FF00.
